sram_rw_port_arbiter: RTL

// - Shares the single RW port of a masked single-port SRAM macro (256x48, 8-bit mask granule) between one read and one write requester.
// - Zero-fills the array after reset or on clear, then arbitrates round-robin between the two requesters.
// - Sits between the cache/table logic and the SRAM macro and drives every macro input.

---
 rtl/sram_rw_port_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sram_rw_port_arbiter.sv
// Arbitrates the single RW port of a masked single-port SRAM macro between one
// read and one write requester, with a zero-fill sweep after reset or clear.
module sram_rw_port_arbiter #(
  parameter int DEPTH         = 256,
  parameter int AW            = 8,
  parameter int DW            = 48,
  parameter int MW            = 6,
  parameter int INIT_ON_RESET = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  output logic          init_done,
  output logic          fsm_state,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_req_addr,
  output logic          rd_resp_valid,
  output logic [DW-1:0] rd_resp_data,
  input  logic          wr_req_valid,
  output logic          wr_req_ready,
  input  logic [AW-1:0] wr_req_addr,
  input  logic [MW-1:0] wr_req_mask,
  input  logic [DW-1:0] wr_req_data,
  output logic [AW-1:0] sram_addr,
  output logic          sram_en,
  output logic          sram_wmode,
  output logic [MW-1:0] sram_wmask,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  // Handshake: a request transfers in the cycle where valid && ready; ready is
  // combinational and never depends on the requester withdrawing valid.
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  typedef enum logic {GR_READ = 1'b0, GR_WRITE = 1'b1} grant_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_t      state, state_next;
  grant_t      last_grant;
  logic [AW:0] init_cnt, init_cnt_next;
  logic        rd_grant, wr_grant;

  assign init_done    = (state == ST_RUN);
  assign fsm_state    = state;
  assign rd_resp_data = sram_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      init_cnt      <= '0;
      last_grant    <= GR_WRITE;
      rd_resp_valid <= 1'b0;
    end else begin
      state         <= state_next;
      init_cnt      <= init_cnt_next;
      rd_resp_valid <= rd_grant;
      if (rd_grant) begin
        last_grant <= GR_READ;
      end else if (wr_grant) begin
        last_grant <= GR_WRITE;
      end
    end
  end

  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    rd_req_ready  = 1'b0;
    wr_req_ready  = 1'b0;
    rd_grant      = 1'b0;
    wr_grant      = 1'b0;
    sram_en       = 1'b0;
    sram_wmode    = 1'b0;
    sram_addr     = '0;
    sram_wmask    = '0;
    sram_wdata    = '0;

    case (state)
      ST_INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_wmask = '1;
        sram_addr  = init_cnt[AW-1:0];
        if (init_cnt == LAST_IDX) begin
          state_next    = ST_RUN;
          init_cnt_next = '0;
        end else begin
          init_cnt_next = init_cnt + (AW+1)'(1);
        end
      end
      ST_RUN: begin
        // With both valid exactly one ready is high, alternating on last_grant.
        rd_req_ready = !wr_req_valid || (last_grant == GR_WRITE);
        wr_req_ready = !rd_req_valid || (last_grant == GR_READ);
        rd_grant     = rd_req_valid && rd_req_ready;
        wr_grant     = wr_req_valid && wr_req_ready;
        if (rd_grant) begin
          sram_en   = 1'b1;
          sram_addr = rd_req_addr;
        end else if (wr_grant) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = wr_req_addr;
          sram_wmask = wr_req_mask;
          sram_wdata = wr_req_data;
        end
      end
      default: state_next = ST_INIT;
    endcase

    // A grant made this cycle still completes; the sweep begins next cycle.
    if (clear) begin
      state_next    = ST_INIT;
      init_cnt_next = '0;
    end
  end

endmodule
